pc_sequencer_param: RTL

- Parametrised program-counter sequencer: the next-generation PC block for the MCU family.
- Generalises the fixed 8-bit PC with reset vector to a configurable address width.
- Adds conditional/relative branching and a hardware return-address stack for CALL/RET.
- Sits between the instruction decoder (which drives op/target/offset/cond) and the instruction memory address port (driven by currentPC).

---
 rtl/pc_sequencer_param.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer_param.sv
// Parametrised program-counter sequencer with branch ops and a return-address stack.
// Define PC_STACK_TRAP_EN to redirect overflowing CALL / underflowing RET to TRAP_VEC.
module pc_sequencer_param #(
    parameter int ADDR_W = 8,
    parameter int STACK_DEPTH = 4,
    parameter int OFFS_W = 8,
    parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(8'hF0)
) (
    input  logic                                  Clk,
    input  logic                                  Reset,
    input  logic [ADDR_W-1:0]                     resetPC,
    input  logic [2:0]                            i_op,
    input  logic [ADDR_W-1:0]                     i_target,
    input  logic [OFFS_W-1:0]                     i_offset,
    input  logic                                  i_cond,
    output logic [ADDR_W-1:0]                     currentPC,
    output logic [$clog2(STACK_DEPTH+1)-1:0]      o_sp,
    output logic                                  o_ovf,
    output logic                                  o_unf
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_INC  = 3'b001,
        OP_JMP  = 3'b010,
        OP_BRC  = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101,
        OP_JMPC = 3'b110,
        OP_RSVD = 3'b111
    } opT;

    logic [ADDR_W-1:0] stackMem [STACK_DEPTH];

    opT                opCur;
    logic [ADDR_W-1:0] pcInc;
    logic [ADDR_W-1:0] offsExt;
    logic [ADDR_W-1:0] ovfPC;
    logic [ADDR_W-1:0] unfPC;
    logic [ADDR_W-1:0] nextPC;
    logic [SP_W-1:0]   nextSp;
    logic [IDX_W-1:0]  pushIdx;
    logic [IDX_W-1:0]  popIdx;
    logic              spFull;
    logic              spEmpty;
    logic              doPush;
    logic              setOvf;
    logic              setUnf;

    assign opCur   = opT'(i_op);
    assign pcInc   = currentPC + ADDR_W'(1);
    assign offsExt = ADDR_W'($signed(i_offset));
    assign spFull  = (o_sp == SP_W'(STACK_DEPTH));
    assign spEmpty = (o_sp == '0);
    assign pushIdx = IDX_W'(o_sp);
    assign popIdx  = IDX_W'(o_sp - SP_W'(1));

`ifdef PC_STACK_TRAP_EN
    assign ovfPC = TRAP_VEC;
    assign unfPC = TRAP_VEC;
`else
    logic unusedTrapVec;
    assign unusedTrapVec = ^TRAP_VEC;
    assign ovfPC = i_target;
    assign unfPC = pcInc;
`endif

    always_comb begin
        nextPC = currentPC;
        nextSp = o_sp;
        doPush = 1'b0;
        setOvf = 1'b0;
        setUnf = 1'b0;
        case (opCur)
            OP_INC:  nextPC = pcInc;
            OP_JMP:  nextPC = i_target;
            OP_BRC:  nextPC = i_cond ? (currentPC + offsExt) : pcInc;
            OP_JMPC: nextPC = i_cond ? i_target : pcInc;
            OP_CALL: begin
                if (spFull) begin
                    // Full stack: the return address is lost, the jump still happens.
                    setOvf = 1'b1;
                    nextPC = ovfPC;
                end else begin
                    doPush = 1'b1;
                    nextSp = o_sp + SP_W'(1);
                    nextPC = i_target;
                end
            end
            OP_RET: begin
                if (spEmpty) begin
                    setUnf = 1'b1;
                    nextPC = unfPC;
                end else begin
                    nextSp = o_sp - SP_W'(1);
                    nextPC = stackMem[popIdx];
                end
            end
            default: nextPC = currentPC;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            currentPC <= resetPC;
            o_sp      <= '0;
            o_ovf     <= 1'b0;
            o_unf     <= 1'b0;
        end else begin
            currentPC <= nextPC;
            o_sp      <= nextSp;
            o_ovf     <= o_ovf | setOvf;
            o_unf     <= o_unf | setUnf;
        end
    end

    // Stack storage has no reset; occupancy alone decides which entries are live.
    always_ff @(posedge Clk) begin
        if (!Reset && doPush) begin
            stackMem[pushIdx] <= pcInc;
        end
    end

endmodule
